seg7_capture: RTL and testbench



---
 rtl/seg7_capture.sv | 113 +++++++++++
 tb/tb_seg7_capture.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// seg7_capture: samples a scanned 7-segment display, decodes each settled digit and publishes 4-digit frames.
// Optional SEG7_CAPTURE_ERRCNT_EN builds a saturating decode-error counter on err_count.
module seg7_capture #(
    parameter bit ACTIVE_LOW     = 1'b1,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  segment_in,
    input  logic [7:0]  digit_in,
    input  logic        clear_err,
    output logic [15:0] value_out,
    output logic [3:0]  dots_out,
    output logic        frame_valid,
    output logic        stale,
    output logic        decode_err,
    output logic [7:0]  err_count
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    logic [7:0]    r_seg_raw, r_dig_raw, r_cnt;
    logic [15:0]   r_prev, r_sh_val;
    logic [3:0]    r_seen, r_sh_dp;
    logic          r_armed;
    logic [IW-1:0] r_idle;

    logic [7:0]  w_seg, w_dig, w_cnt_nxt;
    logic [15:0] w_smp;
    logic [3:0]  w_nib;
    logic        w_legal, w_same, w_cap, w_hex, w_ok, w_err, w_full, w_tmo;

    function automatic logic [4:0] dec(input logic [6:0] s);
        case (s)
            7'h3F: dec = 5'h10;  7'h06: dec = 5'h11;  7'h5B: dec = 5'h12;  7'h4F: dec = 5'h13;
            7'h66: dec = 5'h14;  7'h6D: dec = 5'h15;  7'h7D: dec = 5'h16;  7'h07: dec = 5'h17;
            7'h7F: dec = 5'h18;  7'h6F: dec = 5'h19;  7'h77: dec = 5'h1A;  7'h7C: dec = 5'h1B;
            7'h39: dec = 5'h1C;  7'h5E: dec = 5'h1D;  7'h79: dec = 5'h1E;  7'h71: dec = 5'h1F;
            default: dec = 5'h00;
        endcase
    endfunction

    always_comb begin
        w_seg         = ACTIVE_LOW ? ~r_seg_raw : r_seg_raw;
        w_dig         = ACTIVE_LOW ? ~r_dig_raw : r_dig_raw;
        w_smp         = {w_seg, w_dig};
        w_legal       = (w_dig[7:4] == 4'h0) && $onehot(w_dig[3:0]);
        w_same        = w_smp == r_prev;
        w_cnt_nxt     = !w_legal ? 8'd0 : !w_same ? 8'd1 : (r_cnt == SETTLE) ? r_cnt : r_cnt + 8'd1;
        // armed only blocks while the pattern is unchanged
        w_cap         = w_legal && !(w_same && r_armed) && (w_cnt_nxt == SETTLE);
        {w_hex, w_nib} = dec(w_seg[6:0]);
        w_ok          = w_cap && w_hex;
        w_err         = w_cap && !w_hex;
        w_full        = r_seen == 4'hF;
        w_tmo         = r_idle == IW'(TIMEOUT_CYCLES - 1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_seg_raw   <= {8{ACTIVE_LOW}};
            r_dig_raw   <= {8{ACTIVE_LOW}};
            r_prev      <= '0;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_idle      <= '0;
            r_seen      <= '0;
            r_sh_val    <= '0;
            r_sh_dp     <= '0;
            value_out   <= '0;
            dots_out    <= '0;
            frame_valid <= 1'b0;
            stale       <= 1'b1;
            decode_err  <= 1'b0;
        end else begin
            r_seg_raw   <= segment_in;
            r_dig_raw   <= digit_in;
            r_prev      <= w_smp;
            r_cnt       <= w_cnt_nxt;
            r_armed     <= w_legal && (w_cap || (w_same && r_armed));
            r_idle      <= w_cap ? '0 : w_tmo ? r_idle : r_idle + IW'(1);
            r_seen      <= ((w_full || w_tmo) ? 4'h0 : r_seen) | (w_ok ? w_dig[3:0] : 4'h0);
            frame_valid <= w_full;
            stale       <= w_tmo | (stale & ~w_full);
            decode_err  <= w_err | (decode_err & ~clear_err);
            if (w_full) begin
                value_out <= r_sh_val;
                dots_out  <= r_sh_dp;
            end
            for (int k = 0; k < 4; k++)
                if (w_ok && w_dig[k]) begin
                    r_sh_val[4*k +: 4] <= w_nib;
                    r_sh_dp[k]         <= w_seg[7];
                end
        end
    end

`ifdef SEG7_CAPTURE_ERRCNT_EN
    logic [7:0] r_err_cnt;
    always_ff @(posedge clock) begin
        if (reset)
            r_err_cnt <= '0;
        else if (clear_err)
            r_err_cnt <= {7'b0, w_err};
        else if (w_err && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end
    assign err_count = r_err_cnt;
`else
    assign err_count = 8'h00;
`endif
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed and random scans compared every cycle against a behavioural display-capture model.
module tb_seg7_capture;
    localparam int ST = 4;
    localparam int TO = 100;
    localparam logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clock = 1'b0, reset = 1'b1, clear_err = 1'b0;
    logic [7:0]  segment_in = 8'hFF, digit_in = 8'hFF;
    logic [15:0] value_out;
    logic [3:0]  dots_out;
    logic        frame_valid, stale, decode_err;
    logic [7:0]  err_count;

    seg7_capture #(.ACTIVE_LOW(1'b1), .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .segment_in(segment_in), .digit_in(digit_in),
        .clear_err(clear_err), .value_out(value_out), .dots_out(dots_out),
        .frame_valid(frame_valid), .stale(stale), .decode_err(decode_err), .err_count(err_count)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0, dut_fv = 0, p0;
    logic [15:0] m_reg, m_prev, m_sh, e_val;
    logic [3:0]  m_seen, m_dp, e_dots;
    logic        armed, e_fv, e_stale, e_derr;
    int          run, idle, e_ecnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++)
            if (TBL[i] == s) return i;
        return -1;
    endfunction

    // one clock edge of the reference: sample already registered is judged, pins are then registered
    task automatic model_edge();
        logic [7:0] s, d;
        logic legal, cap;
        int k, n;
        if (reset) begin
            m_reg = 0; m_prev = 0; m_sh = 0; m_seen = 0; m_dp = 0; armed = 0; run = 0; idle = 0;
            e_val = 0; e_dots = 0; e_fv = 0; e_stale = 1; e_derr = 0; e_ecnt = 0;
            return;
        end
        s = m_reg[15:8];
        d = m_reg[7:0];
        legal = (d[7:4] == 0) && ($countones(d[3:0]) == 1);
        cap = 0;
        if (!legal) begin run = 0; armed = 0; end
        else if (m_reg != m_prev) begin run = 1; armed = 0; end
        else if (run < ST) run++;
        if (legal && !armed && run == ST) begin cap = 1; armed = 1; end
        e_fv = (m_seen == 4'hF);
        if (e_fv) begin e_val = m_sh; e_dots = m_dp; e_stale = 0; m_seen = 0; end
        if (idle >= TO - 1) begin m_seen = 0; e_stale = 1; end
        if (clear_err) begin e_derr = 0; e_ecnt = 0; end
        if (cap) begin
            idle = 0;
            k = 0;
            for (int i = 0; i < 4; i++) if (d[i]) k = i;
            n = lookup(s[6:0]);
            if (n >= 0) begin
                m_sh[4*k +: 4] = 4'(n);
                m_dp[k] = s[7];
                m_seen[k] = 1;
            end else begin
                e_derr = 1;
                if (e_ecnt < 255) e_ecnt++;
            end
        end else idle++;
        m_prev = m_reg;
        m_reg = {~segment_in, ~digit_in};
    endtask

    task automatic tick(input logic [7:0] s, input logic [7:0] d, input logic c = 1'b0);
        segment_in = s;
        digit_in = d;
        clear_err = c;
        @(posedge clock);
        model_edge();
        #1;
        if (frame_valid === 1'b1) dut_fv++;
        chk("value", 32'(value_out), 32'(e_val));
        chk("dots", 32'(dots_out), 32'(e_dots));
        chk("frame_valid", 32'(frame_valid), 32'(e_fv));
        chk("stale", 32'(stale), 32'(e_stale));
        chk("decode_err", 32'(decode_err), 32'(e_derr));
`ifdef SEG7_CAPTURE_ERRCNT_EN
        chk("err_count", 32'(err_count), 32'(e_ecnt));
`else
        chk("err_count", 32'(err_count), 32'd0);
`endif
    endtask

    task automatic show(input int k, input logic [7:0] s, input int n);
        for (int j = 0; j < n; j++) tick(s, ~(8'd1 << k));
    endtask

    task automatic blank(input int n);
        for (int j = 0; j < n; j++) tick(8'hFF, 8'hFF);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_value"}, 32'(value_out), 32'd0);
        chk({tag, "_dots"}, 32'(dots_out), 32'd0);
        chk({tag, "_fv"}, 32'(frame_valid), 32'd0);
        chk({tag, "_stale"}, 32'(stale), 32'd1);
        chk({tag, "_derr"}, 32'(decode_err), 32'd0);
        chk({tag, "_ecnt"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        logic [7:0] s, d;
        int k, len;
        reset = 1;
        tick(8'hFF, 8'hFF);
        tick(8'hFF, 8'hFF);
        reset = 0;
        reset_checks("rst");
        // "7","2","8","3", dp off
        p0 = dut_fv;
        show(0, 8'hF8, 6); show(1, 8'hA4, 6); show(2, 8'h80, 6); show(3, 8'hB0, 6);
        blank(3);
        chk("scan1_val", 32'(value_out), 32'h3827);
        chk("scan1_dots", 32'(dots_out), 32'h0);
        chk("scan1_stale", 32'(stale), 32'd0);
        chk("scan1_pulses", 32'(dut_fv - p0), 32'd1);
        // dp lit on digits 1 and 3, long hold on digit 3
        p0 = dut_fv;
        show(0, 8'hF8, 6); show(1, 8'h24, 6); show(2, 8'h80, 6); show(3, 8'h30, 40);
        blank(3);
        chk("dots_val", 32'(value_out), 32'h3827);
        chk("dots_dots", 32'(dots_out), 32'hA);
        chk("hold_pulses", 32'(dut_fv - p0), 32'd1);
        // short dwell on digit 2 must not count
        p0 = dut_fv;
        show(0, 8'hF9, 6); show(1, 8'h99, 6); show(3, 8'h82, 6); show(2, 8'h92, 3);
        tick(8'hFF, 8'hF0); tick(8'hFF, 8'hF0);
        show(2, 8'h92, 3);
        blank(4);
        chk("glitch_pulses", 32'(dut_fv - p0), 32'd0);
        chk("glitch_val", 32'(value_out), 32'h3827);
        show(2, 8'h92, 6);
        blank(3);
        chk("glitch_done_pulses", 32'(dut_fv - p0), 32'd1);
        chk("glitch_done_val", 32'(value_out), 32'h6541);
        // blank pattern on digit 1 is a decode error
        p0 = dut_fv;
        show(1, 8'hFF, 6); blank(2);
        chk("bad_derr", 32'(decode_err), 32'd1);
`ifdef SEG7_CAPTURE_ERRCNT_EN
        chk("bad_ecnt", 32'(err_count), 32'd1);
`endif
        show(1, 8'hFF, 6); blank(2);
`ifdef SEG7_CAPTURE_ERRCNT_EN
        chk("bad_ecnt2", 32'(err_count), 32'd2);
`endif
        // clear held through the error capture: error wins
        for (int j = 0; j < 5; j++) tick(8'hFF, 8'hFD, 1'b1);
        tick(8'hFF, 8'hFD);
        blank(1);
        chk("clr_err_win", 32'(decode_err), 32'd1);
`ifdef SEG7_CAPTURE_ERRCNT_EN
        chk("clr_ecnt_one", 32'(err_count), 32'd1);
`endif
        tick(8'hFF, 8'hFF, 1'b1);
        blank(1);
        chk("clr_derr", 32'(decode_err), 32'd0);
        chk("clr_ecnt", 32'(err_count), 32'd0);
        chk("bad_pulses", 32'(dut_fv - p0), 32'd0);
        // timeout discards digits 0,1
        show(0, 8'hC0, 6); show(1, 8'h90, 6);
        chk("pre_tmo_stale", 32'(stale), 32'd0);
        blank(110);
        chk("tmo_stale", 32'(stale), 32'd1);
        chk("tmo_val", 32'(value_out), 32'h6541);
        p0 = dut_fv;
        show(2, 8'h80, 6); show(3, 8'hB0, 6); blank(3);
        chk("tmo_half_pulses", 32'(dut_fv - p0), 32'd0);
        show(0, 8'hF8, 6); show(1, 8'hA4, 6); blank(3);
        chk("tmo_full_pulses", 32'(dut_fv - p0), 32'd1);
        chk("tmo_full_val", 32'(value_out), 32'h3827);
        chk("tmo_full_stale", 32'(stale), 32'd0);
        // reset mid-frame
        show(0, 8'hF8, 6); show(1, 8'hA4, 6); show(2, 8'h80, 6);
        reset = 1;
        tick(8'hFF, 8'hFF);
        reset = 0;
        reset_checks("mid_rst");
        p0 = dut_fv;
        show(3, 8'hB0, 6); blank(3);
        chk("mid_rst_pulses", 32'(dut_fv - p0), 32'd0);
        chk("mid_rst_stale", 32'(stale), 32'd1);
        // random scans with occasional bad patterns, bad selects, clears and long idles
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 3);
            s = ($urandom_range(0, 9) == 0) ? 8'($urandom) : {1'($urandom), TBL[$urandom_range(0, 15)]};
            d = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << k);
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) tick(~s, ~d, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 39) == 0) blank(120);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
